lookup_map_sched: RTL and testbench

Scheduler that sequences table updates into lookup_map so the pixel path never sees a partly rewritten table mid-frame. Host-side writes (address/data) are buffered in a small FIFO. A commit pulse arms a batch. The batch is drained into lookup_map's di write port only during vertical blanking, detected from the dvi/dtypei frame markers. Sits beside lookup_map in the imager pipeline on the pixel clock.

---
 rtl/lookup_map_sched_pkg.sv | 27 ++
 rtl/lookup_map_sched_fifo.sv | 52 +++++
 rtl/lookup_map_sched.sv | 172 +++++++++++++++++
 tb/tb_lookup_map_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lookup_map_sched_pkg.sv
// Shared frame-marker dtype codes and scheduler state encoding for lookup_map_sched.
// DTYPE_WIDTH falls back to 4 bits when the imager-wide dtypes definition is absent.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

package lookup_map_sched_pkg;

    localparam int DTYPE_W = `DTYPE_WIDTH;

    localparam logic [DTYPE_W-1:0] DTYPE_FRAME_START = DTYPE_W'(1);
    localparam logic [DTYPE_W-1:0] DTYPE_FRAME_END   = DTYPE_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_BLANK = 2'd1,
        ST_ISSUE      = 2'd2,
        ST_GAP        = 2'd3
    } sched_state_t;

    function automatic logic is_marker(input logic valid,
                                       input logic [DTYPE_W-1:0] dtype,
                                       input logic [DTYPE_W-1:0] code);
        return valid && (dtype == code);
    endfunction

endpackage

// File: rtl/lookup_map_sched_fifo.sv
// First-word-fall-through FIFO holding buffered {table index, entry} pairs.
// Pushes while full and pops while empty are dropped; count reports occupancy.
module lookup_map_sched_fifo #(
    parameter int AW    = 4,
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lookup_map_sched.sv
// Buffers host table writes and drains committed batches into lookup_map only during
// vertical blanking. Optional LOOKUP_MAP_SCHED_STATS_EN adds batch/overrun counters.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module lookup_map_sched
    import lookup_map_sched_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_AW    = 4,
    parameter logic [15:0] TERM_ADDR  = 16'h0000
) (
    input  logic                    pixclk,
    input  logic                    resetb,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    commit,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clr_overrun,
    output logic [15:0]             di_term_addr,
    output logic [31:0]             di_reg_addr,
    output logic [DATA_WIDTH-1:0]   di_reg_datai,
    output logic                    di_write_mode,
    output logic                    di_write,
    input  logic                    di_write_rdy
`ifdef LOOKUP_MAP_SCHED_STATS_EN
    ,
    output logic [15:0]             batch_cnt,
    output logic [15:0]             overrun_cnt
`endif
);

    localparam int CW = FIFO_AW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    function automatic logic [31:0] zext_addr(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a);
    endfunction

    sched_state_t          state;
    logic                  in_blank;
    logic [CW-1:0]         armed_cnt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         batch_size;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  draining;
    logic                  frame_start;
    logic                  frame_end;
    logic [EW-1:0]         head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign frame_start  = is_marker(dvi, dtypei, DTYPE_FRAME_START);
    assign frame_end    = is_marker(dvi, dtypei, DTYPE_FRAME_END);
    assign wr_ready     = !full;
    assign push         = wr_valid && !full;
    assign pop          = (state == ST_ISSUE) && di_write_rdy;
    assign draining     = (state == ST_ISSUE) || (state == ST_GAP);
    assign batch_size   = count + CW'(push);
    assign head_addr    = head[EW-1:DATA_WIDTH];
    assign head_data    = head[DATA_WIDTH-1:0];
    assign di_term_addr = TERM_ADDR;

    lookup_map_sched_fifo #(
        .AW    (FIFO_AW),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (pixclk),
        .rst_n (resetb),
        .push  (push),
        .din   ({wr_addr, wr_data}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .count (count)
    );

    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            in_blank <= 1'b1;
        end else if (frame_end) begin
            in_blank <= 1'b1;
        end else if (frame_start) begin
            in_blank <= 1'b0;
        end
    end

    // Commits are only accepted in IDLE with nothing armed, which is exactly !busy.
    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            state         <= ST_IDLE;
            armed_cnt     <= '0;
            busy          <= 1'b0;
            di_write      <= 1'b0;
            di_write_mode <= 1'b0;
            di_reg_addr   <= '0;
            di_reg_datai  <= '0;
        end else begin
            di_write <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (armed_cnt != '0) begin
                        state <= ST_WAIT_BLANK;
                    end else if (commit) begin
                        armed_cnt <= batch_size;
                        busy      <= (batch_size != '0);
                    end
                end
                ST_WAIT_BLANK: begin
                    if (in_blank) begin
                        state         <= ST_ISSUE;
                        di_write_mode <= 1'b1;
                        di_reg_addr   <= zext_addr(head_addr);
                        di_reg_datai  <= head_data;
                    end
                end
                ST_ISSUE: begin
                    if (di_write_rdy) begin
                        di_write  <= 1'b1;
                        armed_cnt <= armed_cnt - CW'(1);
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // The FIFO head already shows the next entry after the pop.
                    if (armed_cnt != '0) begin
                        state        <= ST_ISSUE;
                        di_reg_addr  <= zext_addr(head_addr);
                        di_reg_datai <= head_data;
                    end else begin
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                        di_write_mode <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            overrun <= 1'b0;
        end else if (draining && frame_start) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

`ifdef LOOKUP_MAP_SCHED_STATS_EN
    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            batch_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            if ((state == ST_GAP) && (armed_cnt == '0)) batch_cnt <= batch_cnt + 16'd1;
            if (draining && frame_start) overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lookup_map_sched.sv
// Bench for lookup_map_sched: directed scenarios plus randomized traffic against a
// queue-based scoreboard of buffered and committed table writes.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module tb_lookup_map_sched;
    import lookup_map_sched_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam logic [15:0] TERM = 16'h0000;

    logic                    pixclk = 1'b0;
    logic                    resetb = 1'b0;
    logic                    dvi = 1'b0;
    logic [`DTYPE_WIDTH-1:0] dtypei = '0;
    logic                    wr_valid = 1'b0;
    logic                    wr_ready;
    logic [AW-1:0]           wr_addr = '0;
    logic [DW-1:0]           wr_data = '0;
    logic                    commit = 1'b0;
    logic                    busy;
    logic                    overrun;
    logic                    clr_overrun = 1'b0;
    logic [15:0]             di_term_addr;
    logic [31:0]             di_reg_addr;
    logic [DW-1:0]           di_reg_datai;
    logic                    di_write_mode;
    logic                    di_write;
    logic                    di_write_rdy = 1'b1;
`ifdef LOOKUP_MAP_SCHED_STATS_EN
    logic [15:0]             batch_cnt;
    logic [15:0]             overrun_cnt;
`endif

    always #5 pixclk = ~pixclk;

    lookup_map_sched #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_AW    (4),
        .TERM_ADDR  (TERM)
    ) dut (
        .pixclk        (pixclk),
        .resetb        (resetb),
        .dvi           (dvi),
        .dtypei        (dtypei),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .busy          (busy),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun),
        .di_term_addr  (di_term_addr),
        .di_reg_addr   (di_reg_addr),
        .di_reg_datai  (di_reg_datai),
        .di_write_mode (di_write_mode),
        .di_write      (di_write),
        .di_write_rdy  (di_write_rdy)
`ifdef LOOKUP_MAP_SCHED_STATS_EN
        ,
        .batch_cnt     (batch_cnt),
        .overrun_cnt   (overrun_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the buffered entries, how many of them the last accepted commit
    // still owes to lookup_map, and how long ago the last write strobe was seen.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   wcyc[$];
    int   outstanding = 0;
    int   idle = 100;
    int   cyc = 0;
    int   n_writes = 0;
    logic m_blank = 1'b1;
    logic prev_dw = 1'b0;

    always @(posedge pixclk) begin
        cyc++;
        if (!resetb) begin
            mq.delete();
            outstanding = 0;
            idle = 100;
            m_blank = 1'b1;
            prev_dw = 1'b0;
        end else begin
            if (wr_valid && mq.size() < 16) mq.push_back('{wr_addr, wr_data});
            if (commit && outstanding == 0) outstanding = mq.size();
            if (dvi && dtypei == DTYPE_FRAME_END) m_blank = 1'b1;
            else if (dvi && dtypei == DTYPE_FRAME_START) m_blank = 1'b0;
            #1;
            if (resetb) begin
                if (di_write) begin
                    check_eq("write_armed", 64'(outstanding != 0), 64'd1);
                    check_eq("write_gap", 64'(prev_dw), 64'd0);
                    check_eq("write_mode", 64'(di_write_mode), 64'd1);
                    if (mq.size() > 0) begin
                        check_eq("write_addr", 64'(di_reg_addr), 64'(32'(mq[0].a)));
                        check_eq("write_data", 64'(di_reg_datai), 64'(mq[0].d));
                        void'(mq.pop_front());
                    end
                    if (outstanding > 0) outstanding--;
                    idle = 0;
                    n_writes++;
                    wcyc.push_back(cyc);
                end else if (idle < 100) begin
                    idle++;
                end
                prev_dw = di_write;
                check_eq("wr_ready", 64'(wr_ready), 64'(mq.size() < 16));
                check_eq("busy", 64'(busy), 64'((outstanding > 0) || (idle == 0)));
            end
        end
    end

    task automatic tick();
        @(negedge pixclk);
    endtask

    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic marker(input logic [`DTYPE_WIDTH-1:0] dt);
        dvi    = 1'b1;
        dtypei = dt;
        tick();
        dvi    = 1'b0;
        dtypei = '0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(outstanding == 0 && idle >= 2) && k < budget) begin
            tick();
            k++;
        end
        check_eq("idle_reached", 64'(outstanding == 0 && idle >= 2), 64'd1);
    endtask

    task automatic wait_outstanding_le(input int target, input int budget);
        int k = 0;
        while (outstanding > target && k < budget) begin
            tick();
            k++;
        end
        check_eq("drain_progress", 64'(outstanding <= target), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int e_cyc;
        int lat;
        int r;
        logic [31:0] hold_addr;

        tick();
        repeat (3) tick();
        check_eq("rst_di_write", 64'(di_write), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
        check_eq("rst_wr_ready", 64'(wr_ready), 64'd1);
        check_eq("rst_term_addr", 64'(di_term_addr), 64'(TERM));
        check_eq("rst_reg_addr", 64'(di_reg_addr), 64'd0);
        check_eq("rst_reg_data", 64'(di_reg_datai), 64'd0);
        check_eq("rst_write_mode", 64'(di_write_mode), 64'd0);
        resetb = 1'b1;
        tick();

        // Four entries committed while already in blank.
        w0 = n_writes;
        for (int i = 0; i < 4; i++) push_one(AW'(i), 32'hA0 + 32'(i));
        commit_pulse();
        wait_idle(100);
        check_eq("t1_writes", 64'(n_writes - w0), 64'd4);
        if (n_writes - w0 == 4) check_eq("t1_span", 64'(wcyc[w0 + 3] - wcyc[w0]), 64'd6);
        check_eq("t1_busy_low", 64'(busy), 64'd0);

        // Batch committed mid-frame waits for FRAME_END.
        marker(DTYPE_FRAME_START);
        w0 = n_writes;
        for (int i = 0; i < 3; i++) push_one(AW'(10 + i), 32'hB000 + 32'(i));
        commit_pulse();
        repeat (20) tick();
        check_eq("t2_waiting", 64'(outstanding), 64'd3);
        check_eq("t2_no_overrun", 64'(overrun), 64'd0);
        marker(DTYPE_FRAME_END);
        e_cyc = cyc;
        wait_outstanding_le(2, 20);
        lat = (n_writes > w0) ? wcyc[w0] - e_cyc : 99;
        check_eq("t2_latency_ok", 64'(lat >= 1 && lat <= 2), 64'd1);
        wait_idle(100);
        check_eq("t2_writes", 64'(n_writes - w0), 64'd3);

        // FRAME_START after the second of eight writes.
        w0 = n_writes;
        for (int i = 0; i < 8; i++) push_one(AW'(100 + i), $urandom);
        commit_pulse();
        wait_outstanding_le(6, 50);
        marker(DTYPE_FRAME_START);
        wait_idle(100);
        check_eq("t3_writes", 64'(n_writes - w0), 64'd8);
        check_eq("t3_overrun_set", 64'(overrun), 64'd1);
        repeat (4) tick();
        check_eq("t3_overrun_sticky", 64'(overrun), 64'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check_eq("t3_overrun_clr", 64'(overrun), 64'd0);
        marker(DTYPE_FRAME_END);

        // Fill the FIFO past capacity, then drain it.
        w0 = n_writes;
        for (int i = 0; i < 17; i++) push_one(AW'($urandom), $urandom);
        check_eq("t4_full", 64'(wr_ready), 64'd0);
        commit_pulse();
        wait_idle(100);
        check_eq("t4_writes", 64'(n_writes - w0), 64'd16);
        check_eq("t4_ready_again", 64'(wr_ready), 64'd1);
        w0 = n_writes;
        commit_pulse();
        repeat (10) tick();
        check_eq("t4_empty_commit", 64'(n_writes - w0), 64'd0);

        // Only armed entries drain; a commit while busy is ignored.
        w0 = n_writes;
        push_one(AW'(500), 32'hC0);
        push_one(AW'(501), 32'hC1);
        commit_pulse();
        push_one(AW'(502), 32'hC2);
        push_one(AW'(503), 32'hC3);
        commit_pulse();
        wait_idle(100);
        check_eq("t5_first_batch", 64'(n_writes - w0), 64'd2);
        commit_pulse();
        wait_idle(100);
        check_eq("t5_second_batch", 64'(n_writes - w0), 64'd4);

        // Randomized traffic; FRAME_START only while nothing is draining.
        for (int i = 0; i < 800; i++) begin
            wr_valid     = ($urandom_range(0, 2) == 0);
            wr_addr      = AW'($urandom);
            wr_data      = $urandom;
            di_write_rdy = ($urandom_range(0, 3) != 0);
            commit       = 1'b0;
            if (outstanding == 0 && idle >= 2) commit = ($urandom_range(0, 7) == 0);
            else if (outstanding > 0) commit = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 15);
            dvi    = 1'b0;
            dtypei = '0;
            case (r)
                0: if (outstanding == 0 && idle >= 2) begin
                       dvi = 1'b1;
                       dtypei = DTYPE_FRAME_START;
                   end
                1: begin dvi = 1'b1; dtypei = DTYPE_FRAME_END; end
                2: begin dvi = 1'b1; dtypei = `DTYPE_WIDTH'(3); end
                3: begin dvi = 1'b0; dtypei = DTYPE_FRAME_START; end
                default: ;
            endcase
            tick();
        end
        wr_valid = 1'b0;
        commit = 1'b0;
        dvi = 1'b0;
        dtypei = '0;
        di_write_rdy = 1'b1;
        marker(DTYPE_FRAME_END);
        wait_idle(200);
        commit_pulse();
        wait_idle(200);
        check_eq("rand_busy_low", 64'(busy), 64'd0);
        check_eq("rand_no_overrun", 64'(overrun), 64'd0);

        // Stall in ISSUE, then reset in the middle of the batch.
        di_write_rdy = 1'b0;
        for (int i = 0; i < 5; i++) push_one(AW'(700 + i), 32'hD00 + 32'(i));
        commit_pulse();
        repeat (4) tick();
        w0 = n_writes;
        hold_addr = 32'(mq[0].a);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t7_stall_write", 64'(di_write), 64'd0);
            check_eq("t7_stall_addr", 64'(di_reg_addr), 64'(hold_addr));
            check_eq("t7_stall_data", 64'(di_reg_datai), 64'(32'hD00));
        end
        check_eq("t7_stall_count", 64'(n_writes - w0), 64'd0);
        di_write_rdy = 1'b1;
        wait_outstanding_le(3, 20);
        resetb = 1'b0;
        #1;
        check_eq("t7_rst_write", 64'(di_write), 64'd0);
        check_eq("t7_rst_busy", 64'(busy), 64'd0);
        check_eq("t7_rst_ready", 64'(wr_ready), 64'd1);
        check_eq("t7_rst_mode", 64'(di_write_mode), 64'd0);
        tick();
        tick();
        resetb = 1'b1;
        tick();
        w0 = n_writes;
        commit_pulse();
        repeat (10) tick();
        check_eq("t7_fifo_empty", 64'(n_writes - w0), 64'd0);
        push_one(AW'(3), 32'hE1);
        commit_pulse();
        wait_idle(100);
        check_eq("t7_post_reset", 64'(n_writes - w0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
